// File: rtl/vector_lsu.sv
// Vector load/store unit: moves up to vl elements of vsew width between the vector datapath and an
// OBI-style data port, one bus transaction per element. Optional macro: VLSU_MISALIGN_CHECK_EN.
module vector_lsu (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic         store,
  input  logic [31:0]  base_addr,
  input  logic [31:0]  stride,
  input  logic [4:0]   vl,
  input  logic [1:0]   vsew,
  input  logic [127:0] vs3_data,
  output logic [127:0] load_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         data_req,
  input  logic         data_gnt,
  output logic [31:0]  data_addr,
  output logic         data_we,
  output logic [3:0]   data_be,
  output logic [31:0]  data_wdata,
  input  logic         data_rvalid,
  input  logic [31:0]  data_rdata,
  input  logic         data_err
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          store_q, store_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   stride_q, stride_d;
  logic [4:0]    vl_q, vl_d;
  logic [1:0]    sew_q, sew_d;
  logic [127:0]  vs3_q, vs3_d;
  logic [127:0]  load_q, load_d;
  logic          error_q, error_d;

  logic [31:0]   eff_addr;
  logic [31:0]   next_addr;
  logic [1:0]    lane;
  logic          last_elem;
  logic [31:0]   elem;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [31:0]   rd_lane;

`ifdef VLSU_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sew);
    return ((sew == 2'd1) && a[0]) || ((sew == 2'd2) && (a[1:0] != 2'b00));
  endfunction

  assign eff_addr = addr_q;
`else
  // Misaligned low bits are dropped so the access lands on the containing SEW-aligned slot.
  always_comb begin
    eff_addr = addr_q;
    if (sew_q == 2'd1)      eff_addr[0]   = 1'b0;
    else if (sew_q == 2'd2) eff_addr[1:0] = 2'b00;
  end
`endif

  assign lane      = eff_addr[1:0];
  assign next_addr = addr_q + stride_q;
  assign last_elem = ({1'b0, idx_q} == (vl_q - 5'd1));

  // 32b elements beyond the register width wrap onto the available lanes.
  always_comb begin
    case (sew_q)
      2'd0:    elem = {24'd0, vs3_q[{idx_q, 3'b000} +: 8]};
      2'd1:    elem = {16'd0, vs3_q[{idx_q[2:0], 4'b0000} +: 16]};
      default: elem = vs3_q[{idx_q[1:0], 5'b00000} +: 32];
    endcase
  end

  always_comb begin
    case (sew_q)
      2'd0: begin
        wdata   = {4{elem[7:0]}};
        be      = 4'b0001 << lane;
        rd_lane = {24'd0, data_rdata[{lane, 3'b000} +: 8]};
      end
      2'd1: begin
        wdata   = {2{elem[15:0]}};
        be      = lane[1] ? 4'b1100 : 4'b0011;
        rd_lane = {16'd0, (lane[1] ? data_rdata[31:16] : data_rdata[15:0])};
      end
      default: begin
        wdata   = elem;
        be      = 4'hF;
        rd_lane = data_rdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      store_q  <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      sew_q    <= '0;
      vs3_q    <= '0;
      load_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      store_q  <= store_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      vl_q     <= vl_d;
      sew_q    <= sew_d;
      vs3_q    <= vs3_d;
      load_q   <= load_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    store_d  = store_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    vl_d     = vl_q;
    sew_d    = sew_q;
    vs3_d    = vs3_q;
    load_d   = load_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          store_d  = store;
          addr_d   = base_addr;
          stride_d = stride;
          vl_d     = vl;
          sew_d    = vsew;
          vs3_d    = vs3_data;
          idx_d    = '0;
          error_d  = 1'b0;
          if (!store) load_d = '0;
          if (vsew == 2'd3) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (vl == 5'd0) begin
            state_d = S_DONE;
          end
`ifdef VLSU_MISALIGN_CHECK_EN
          else if (misaligned(base_addr, vsew)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end
`endif
          else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (data_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_rvalid) begin
          if (!store_q) begin
            case (sew_q)
              2'd0:    load_d[{idx_q, 3'b000} +: 8]         = rd_lane[7:0];
              2'd1:    load_d[{idx_q[2:0], 4'b0000} +: 16]  = rd_lane[15:0];
              default: load_d[{idx_q[1:0], 5'b00000} +: 32] = rd_lane;
            endcase
          end
          if (data_err) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (last_elem) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + 4'd1;
            addr_d = next_addr;
`ifdef VLSU_MISALIGN_CHECK_EN
            if (misaligned(next_addr, sew_q)) begin
              error_d = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_REQ;
            end
`else
            state_d = S_REQ;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    error      = error_q;
    load_data  = load_q;
    data_req   = (state_q == S_REQ);
    data_we    = (state_q == S_REQ) && store_q;
    data_be    = (state_q == S_REQ) ? be : 4'h0;
    data_addr  = (state_q == S_REQ) ? eff_addr : 32'h0;
    data_wdata = (state_q == S_REQ) ? wdata : 32'h0;
  end
endmodule

// File: tb/tb_vector_lsu.sv
// Directed self-checking bench for vector_lsu with a simple OBI memory responder.
module tb_vector_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_reset = 1'b0;
  logic         start = 1'b0;
  logic         store = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [31:0]  stride = '0;
  logic [4:0]   vl = '0;
  logic [1:0]   vsew = '0;
  logic [127:0] vs3_data = '0;
  logic [127:0] load_data;
  logic         busy, done, error, data_req, data_we;
  logic         data_gnt = 1'b0, data_rvalid = 1'b0, data_err = 1'b0;
  logic [31:0]  data_addr, data_wdata;
  logic [31:0]  data_rdata = '0;
  logic [3:0]   data_be;

  int total = 0;
  int bad = 0;

  vector_lsu dut (
    .clk(clk), .n_reset(n_reset), .start(start), .store(store),
    .base_addr(base_addr), .stride(stride), .vl(vl), .vsew(vsew),
    .vs3_data(vs3_data), .load_data(load_data), .busy(busy), .done(done),
    .error(error), .data_req(data_req), .data_gnt(data_gnt), .data_addr(data_addr),
    .data_we(data_we), .data_be(data_be), .data_wdata(data_wdata),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err)
  );

  // Memory responder: grants on the falling edge, answers after resp_delay extra cycles.
  logic [7:0]  mem [0:4095];
  logic [31:0] log_addr [0:31];
  logic [31:0] log_wdata [0:31];
  logic [3:0]  log_be [0:31];
  logic        log_we [0:31];
  logic [31:0] stall_addr [0:7];
  logic [31:0] stall_wdata [0:7];
  int gnt_count = 0, req_cycles = 0, stall_idx = -1, stall_left = 0, stall_n = 0;
  int err_idx = -1, resp_delay = 0, pend_wait = 0, pend_idx = 0;
  logic        pend_active = 1'b0;
  logic [31:0] pend_addr = '0;

  always @(negedge clk) begin
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    data_rdata  = '0;
    data_gnt    = 1'b0;
    if (pend_active) begin
      if (pend_wait == 0) begin
        data_rvalid = 1'b1;
        data_rdata  = {mem[{pend_addr[11:2], 2'b11}], mem[{pend_addr[11:2], 2'b10}],
                       mem[{pend_addr[11:2], 2'b01}], mem[{pend_addr[11:2], 2'b00}]};
        data_err    = (pend_idx == err_idx);
        pend_active = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    if (data_req) begin
      req_cycles++;
      if (stall_left > 0 && gnt_count == stall_idx) begin
        stall_addr[stall_n]  = data_addr;
        stall_wdata[stall_n] = data_wdata;
        stall_n++;
        stall_left--;
      end else begin
        data_gnt = 1'b1;
        log_addr[gnt_count]  = data_addr;
        log_wdata[gnt_count] = data_wdata;
        log_be[gnt_count]    = data_be;
        log_we[gnt_count]    = data_we;
        pend_active = 1'b1;
        pend_wait   = resp_delay;
        pend_addr   = data_addr;
        pend_idx    = gnt_count;
        gnt_count++;
      end
    end
  end

  task automatic clear_resp();
    gnt_count = 0; req_cycles = 0; stall_idx = -1; stall_left = 0; stall_n = 0;
    err_idx = -1; resp_delay = 0; pend_active = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    mem[a] = w[7:0]; mem[a+1] = w[15:8]; mem[a+2] = w[23:16]; mem[a+3] = w[31:24];
  endtask

  task automatic run_cmd(input logic st, input logic [31:0] b, input logic [31:0] s,
                         input logic [4:0] n, input logic [1:0] w, input logic [127:0] v,
                         output int dc, output logic req1);
    int cyc;
    @(posedge clk); #1;
    start = 1'b1; store = st; base_addr = b; stride = s; vl = n; vsew = w; vs3_data = v;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    req1 = data_req;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    dc = done ? cyc : -1;
    $display("cmd %s base=%h stride=%h vl=%0d sew=%0d done_cycle=%0d err=%b reqs=%0d",
             st ? "store" : "load", b, s, n, w, dc, error, gnt_count);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, error, data_req, data_we, data_be, data_addr, data_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0",
                      {busy, done, error, data_req, data_we, data_be, data_addr, data_wdata});
    end
    total++;
    if (load_data !== '0) begin bad++; $display("FAIL reset_load_data: got %h want 0", load_data); end
    n_reset = 1'b1;
  endtask

  task automatic test_unit_load8();
    int dc; logic r1;
    clear_resp();
    for (int k = 0; k < 16; k++) mem[256 + k] = 8'(k + 1);
    run_cmd(1'b0, 32'h100, 32'd1, 5'd16, 2'd0, '0, dc, r1);
    total++; if (r1 !== 1'b1) begin bad++; $display("FAIL u8_req_rise: got %b want 1", r1); end
    total++; if (dc != 33) begin bad++; $display("FAIL u8_done_cycle: got %0d want 33", dc); end
    total++;
    if (load_data !== 128'h100F0E0D0C0B0A090807060504030201) begin
      bad++; $display("FAIL u8_load_data: got %h want 100f0e0d0c0b0a090807060504030201", load_data);
    end
    total++; if (gnt_count != 16) begin bad++; $display("FAIL u8_req_count: got %0d want 16", gnt_count); end
    total++;
    if (log_addr[5] !== 32'h105 || log_be[5] !== 4'b0010 || log_we[5] !== 1'b0) begin
      bad++; $display("FAIL u8_elem5: got addr=%h be=%b we=%b want 105 0010 0", log_addr[5], log_be[5], log_we[5]);
    end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL u8_error: got %b want 0", error); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL u8_after_done: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_store32_stall();
    int dc; logic r1;
    logic [31:0] exp_w [0:3];
    exp_w[0] = 32'hAAAAAAAA; exp_w[1] = 32'hBBBBBBBB; exp_w[2] = 32'hCCCCCCCC; exp_w[3] = 32'hDDDDDDDD;
    clear_resp();
    stall_idx = 1; stall_left = 3;
    run_cmd(1'b1, 32'h200, 32'd4, 5'd4, 2'd2,
            {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, dc, r1);
    total++; if (dc != 12) begin bad++; $display("FAIL s32_done_cycle: got %0d want 12", dc); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[i] !== 32'h200 + 32'(4 * i) || log_be[i] !== 4'hF || log_we[i] !== 1'b1 || log_wdata[i] !== exp_w[i]) begin
        bad++; $display("FAIL s32_elem%0d: got addr=%h be=%h we=%b wdata=%h want %h f 1 %h",
                        i, log_addr[i], log_be[i], log_we[i], log_wdata[i], 32'h200 + 32'(4 * i), exp_w[i]);
      end
    end
    total++; if (stall_n != 3) begin bad++; $display("FAIL s32_stall_cycles: got %0d want 3", stall_n); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (stall_addr[i] !== 32'h204 || stall_wdata[i] !== 32'hBBBBBBBB) begin
        bad++; $display("FAIL s32_stall_stable%0d: got addr=%h wdata=%h want 204 bbbbbbbb", i, stall_addr[i], stall_wdata[i]);
      end
    end
    total++;
    if (load_data !== 128'h100F0E0D0C0B0A090807060504030201) begin
      bad++; $display("FAIL s32_load_data_kept: got %h want 100f0e0d0c0b0a090807060504030201", load_data);
    end
  endtask

  task automatic test_strided_load16();
    int dc; logic r1;
    clear_resp();
    mem[12'h402] = 8'h34; mem[12'h403] = 8'h12;
    mem[12'h3FC] = 8'h78; mem[12'h3FD] = 8'h56;
    mem[12'h3F6] = 8'hBC; mem[12'h3F7] = 8'h9A;
    run_cmd(1'b0, 32'h402, 32'hFFFFFFFA, 5'd3, 2'd1, '0, dc, r1);
    total++; if (dc != 7) begin bad++; $display("FAIL h16_done_cycle: got %0d want 7", dc); end
    total++;
    if (log_addr[0] !== 32'h402 || log_addr[1] !== 32'h3FC || log_addr[2] !== 32'h3F6) begin
      bad++; $display("FAIL h16_addrs: got %h %h %h want 402 3fc 3f6", log_addr[0], log_addr[1], log_addr[2]);
    end
    total++;
    if (log_be[0] !== 4'hC || log_be[1] !== 4'h3 || log_be[2] !== 4'hC) begin
      bad++; $display("FAIL h16_be: got %h %h %h want c 3 c", log_be[0], log_be[1], log_be[2]);
    end
    total++;
    if (load_data !== {80'h0, 16'h9ABC, 16'h5678, 16'h1234}) begin
      bad++; $display("FAIL h16_load_data: got %h want %h", load_data, {80'h0, 16'h9ABC, 16'h5678, 16'h1234});
    end
  endtask

  task automatic test_bus_error();
    int dc; logic r1;
    clear_resp();
    err_idx = 2;
    set_word(12'h300, 32'hA0A1A2A3); set_word(12'h304, 32'hB0B1B2B3);
    set_word(12'h308, 32'hC0C1C2C3); set_word(12'h30C, 32'hD0D1D2D3);
    run_cmd(1'b0, 32'h300, 32'd4, 5'd4, 2'd2, '0, dc, r1);
    total++; if (dc != 7) begin bad++; $display("FAIL berr_done_cycle: got %0d want 7", dc); end
    total++; if (gnt_count != 3) begin bad++; $display("FAIL berr_req_count: got %0d want 3", gnt_count); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL berr_error: got %b want 1", error); end
    total++;
    if (load_data[63:0] !== 64'hB0B1B2B3A0A1A2A3 || load_data[127:96] !== 32'h0) begin
      bad++; $display("FAIL berr_load_data: got %h want elems0-1 b0b1b2b3a0a1a2a3, elem3 0", load_data);
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (error !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL berr_error_held: got error=%b busy=%b want 1 0", error, busy); end
  endtask

  task automatic test_edge_cases();
    int dc; logic r1;
    clear_resp();
    run_cmd(1'b0, 32'h100, 32'd1, 5'd0, 2'd0, '0, dc, r1);
    total++; if (dc != 1) begin bad++; $display("FAIL vl0_done_cycle: got %0d want 1", dc); end
    total++; if (req_cycles != 0) begin bad++; $display("FAIL vl0_no_req: got %0d req cycles want 0", req_cycles); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL vl0_error: got %b want 0", error); end
    clear_resp();
    run_cmd(1'b0, 32'h100, 32'd4, 5'd4, 2'd3, '0, dc, r1);
    total++; if (dc != 1) begin bad++; $display("FAIL sew3_done_cycle: got %0d want 1", dc); end
    total++; if (error !== 1'b1 || req_cycles != 0) begin bad++; $display("FAIL sew3_error: got error=%b reqs=%0d want 1 0", error, req_cycles); end
  endtask

  task automatic test_reset_in_wait();
    clear_resp();
    resp_delay = 1;
    set_word(12'h500, 32'h13572468);
    @(posedge clk); #1;
    start = 1'b1; store = 1'b0; base_addr = 32'h500; stride = 32'd4; vl = 5'd2; vsew = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1 || data_req !== 1'b0) begin bad++; $display("FAIL rst_in_wait: got busy=%b req=%b want 1 0", busy, data_req); end
    n_reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done, error, data_req, data_we, data_be, data_addr, data_wdata} !== '0 || load_data !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: got %b load=%h want 0",
                      {busy, done, error, data_req, data_we, data_be, data_addr, data_wdata}, load_data);
    end
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || load_data !== '0) begin
        bad++; $display("FAIL rst_late_rvalid%0d: got done=%b busy=%b load=%h want 0 0 0", i, done, busy, load_data);
      end
    end
    $display("cmd reset-in-wait checked");
  endtask

  task automatic test_misalign();
    int dc; logic r1;
    clear_resp();
    set_word(12'h100, 32'h89ABCDEF);
    run_cmd(1'b0, 32'h102, 32'd4, 5'd1, 2'd2, '0, dc, r1);
`ifdef VLSU_MISALIGN_CHECK_EN
    total++; if (dc != 1) begin bad++; $display("FAIL mis_done_cycle: got %0d want 1", dc); end
    total++; if (error !== 1'b1 || req_cycles != 0) begin bad++; $display("FAIL mis_abort: got error=%b reqs=%0d want 1 0", error, req_cycles); end
`else
    total++; if (dc != 3) begin bad++; $display("FAIL mis_done_cycle: got %0d want 3", dc); end
    total++; if (log_addr[0] !== 32'h100 || log_be[0] !== 4'hF) begin bad++; $display("FAIL mis_addr: got %h be=%h want 100 f", log_addr[0], log_be[0]); end
    total++; if (load_data !== 128'h89ABCDEF || error !== 1'b0) begin bad++; $display("FAIL mis_data: got %h err=%b want 89abcdef 0", load_data, error); end
`endif
  endtask

  initial begin
    clear_resp();
    test_reset();
    test_unit_load8();
    test_store32_stall();
    test_strided_load16();
    test_bus_error();
    test_edge_cases();
    test_reset_in_wait();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
